adc_audio_conditioner: RTL and testbench

Conditions the raw 12-bit MCP3202 ADC stream into signed 16-bit PCM for the HDMI audio sample path. It sits between the SPI ADC core's `DATA_VALID`/`o_DATA` outputs and the low-pass/HDMI sample word. The processing chain is: unsigned-to-signed conversion, boxcar decimation, DC-offset removal, a soft-start gain ramp after enable, and saturation with overrange and overrun flags.

---
 rtl/adc_audio_conditioner_if.sv | 22 ++
 rtl/adc_audio_conditioner.sv | 191 +++++++++++++++++++
 tb/tb_adc_audio_conditioner.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_audio_conditioner_if.sv
// Sample-path bundle between the SPI ADC core and the audio conditioner.
// The master side drives the ADC strobe/data and the enable level; the
// slave side (the conditioner) returns the PCM word and its status pulses.
interface adc_audio_conditioner_if;
  logic        enable;
  logic        in_valid;
  logic [11:0] in_sample;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        overrange;
  logic        overrun;

  modport master (
    output enable, in_valid, in_sample,
    input  out_sample, out_valid, overrange, overrun
  );

  modport slave (
    input  enable, in_valid, in_sample,
    output out_sample, out_valid, overrange, overrun
  );
endinterface

// File: rtl/adc_audio_conditioner.sv
// Turns the unsigned 12-bit MCP3202 stream into signed 16-bit PCM:
// offset-binary to two's complement, boxcar decimation, DC removal,
// soft-start gain ramp after enable, and saturation with status pulses.
module adc_audio_conditioner #(
  parameter int AVG_LOG2  = 2,
  parameter int DC_SHIFT  = 10,
  parameter int RAMP_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  adc_audio_conditioner_if.slave audio
);
  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DW = 16 + DC_SHIFT;
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = 17 + RAMP_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [GW-1:0] G_UNITY  = GW'(1 << RAMP_LOG2);

  typedef enum logic [2:0] {S_OFF, S_ACCUM, S_FILTER, S_SCALE, S_EMIT} state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [15:0]   avg_q, avg_d;
  logic signed [DW-1:0] dc_acc_q, dc_acc_d;
  logic signed [16:0]   hp_q, hp_d;
  logic signed [15:0]   y_q, y_d;
  logic                 clip_q, clip_d;
  logic [GW-1:0]        g_q, g_d;
  logic [15:0]          out_sample_q, out_sample_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrange_q, overrange_d;
  logic                 overrun_q, overrun_d;

  logic signed [15:0]   x;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] sum;
  logic signed [15:0]   avg;
  logic                 group_done;
  logic                 handoff;
  logic signed [15:0]   dc;
  logic signed [16:0]   hp_new;
  logic signed [15:0]   hs;
  logic                 hs_clip;
  logic signed [PW-1:0] prod;
  logic signed [15:0]   y;
  logic                 unused_prod_bits;

  // Offset binary to two's complement: flipping the MSB moves 0x800 to zero.
  assign x     = {~audio.in_sample[11], audio.in_sample[10:0], 4'b0000};
  assign x_ext = AW'(x);
  assign sum   = acc_q + x_ext;
  // Arithmetic shift by AVG_LOG2 is just the upper 16 bits of the sum.
  assign avg   = sum[AW-1:AVG_LOG2];

  assign group_done = (cnt_q == CNT_LAST);
  assign handoff    = audio.in_valid && group_done;

  // DC estimate is the tracker's integer part; hp uses it before the update.
  assign dc     = dc_acc_q[DW-1:DC_SHIFT];
  assign hp_new = 17'(avg_q) - 17'(dc);

  // Clip the 17-bit high-pass result into the 16-bit PCM range.
  always_comb begin
    hs      = hp_q[15:0];
    hs_clip = 1'b0;
    if (hp_q > 17'sd32767) begin
      hs      = 16'sh7FFF;
      hs_clip = 1'b1;
    end else if (hp_q < -17'sd32768) begin
      hs      = 16'sh8000;
      hs_clip = 1'b1;
    end
  end

  // Gain is g / 2^RAMP_LOG2; g = 2^RAMP_LOG2 passes hs through unchanged.
  assign prod = PW'(hs) * PW'($signed({1'b0, g_q}));
  assign y    = prod[RAMP_LOG2 +: 16];
  assign unused_prod_bits = ^{prod[PW-1], prod[RAMP_LOG2-1:0]};

  // Next-state and datapath decisions for the whole pipeline.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    avg_d        = avg_q;
    dc_acc_d     = dc_acc_q;
    hp_d         = hp_q;
    y_d          = y_q;
    clip_d       = clip_q;
    g_d          = g_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    overrange_d  = 1'b0;
    overrun_d    = 1'b0;

    if (!audio.enable || state_q == S_OFF) begin
      // Off (or leaving for off): in-flight work is abandoned and the ramp
      // restarts; the DC tracker and the last output word are kept.
      acc_d   = '0;
      cnt_d   = '0;
      g_d     = '0;
      state_d = audio.enable ? S_ACCUM : S_OFF;
    end else begin
      // Decimation runs independently of where the pipeline is.
      if (audio.in_valid) begin
        if (group_done) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
      end

      case (state_q)
        S_ACCUM: begin
          if (handoff) begin
            avg_d   = avg;
            state_d = S_FILTER;
          end
        end
        S_FILTER: begin
          hp_d     = hp_new;
          dc_acc_d = dc_acc_q + DW'(hp_new);
          state_d  = S_SCALE;
        end
        S_SCALE: begin
          y_d     = y;
          clip_d  = hs_clip;
          state_d = S_EMIT;
        end
        S_EMIT: begin
          out_sample_d = y_q;
          out_valid_d  = 1'b1;
          overrange_d  = clip_q;
          if (g_q < G_UNITY) begin
            g_d = g_q + 1'b1;
          end
          state_d = S_ACCUM;
        end
        default: state_d = S_OFF;
      endcase

      // A group finishing while the pipeline is busy has nowhere to go.
      if (handoff && state_q != S_ACCUM) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OFF;
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_q        <= '0;
      dc_acc_q     <= '0;
      hp_q         <= '0;
      y_q          <= '0;
      clip_q       <= 1'b0;
      g_q          <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrange_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      avg_q        <= avg_d;
      dc_acc_q     <= dc_acc_d;
      hp_q         <= hp_d;
      y_q          <= y_d;
      clip_q       <= clip_d;
      g_q          <= g_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrange_q  <= overrange_d;
      overrun_q    <= overrun_d;
    end
  end

  assign audio.out_sample = out_sample_q;
  assign audio.out_valid  = out_valid_q;
  assign audio.overrange  = overrange_q;
  assign audio.overrun    = overrun_q;
endmodule

// File: tb/tb_adc_audio_conditioner.sv
// Bench for adc_audio_conditioner: three parameterisations share one
// stimulus stream; a transaction-level model predicts every output cycle.
// Instance 0: defaults (AVG 2, DC 10, RAMP 8)
// Instance 1: AVG 2, DC 4, RAMP 1
// Instance 2: AVG 0, DC 4, RAMP 1
module tb_adc_audio_conditioner;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [11:0] in_sample;

  logic [2:0][15:0] d_sample;
  logic [2:0]       d_valid;
  logic [2:0]       d_ovr;
  logic [2:0]       d_orun;

  int checks = 0;
  int errors = 0;

  function automatic int pa(input int i); return (i == 2) ? 0 : 2; endfunction
  function automatic int pd(input int i); return (i == 0) ? 10 : 4; endfunction
  function automatic int pr(input int i); return (i == 0) ? 8 : 1; endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    adc_audio_conditioner_if ifc ();
    assign ifc.enable    = enable;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_sample = in_sample;
    adc_audio_conditioner #(
      .AVG_LOG2 (gi == 2 ? 0 : 2),
      .DC_SHIFT (gi == 0 ? 10 : 4),
      .RAMP_LOG2(gi == 0 ? 8 : 1)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .audio(ifc)
    );
    assign d_sample[gi] = ifc.out_sample;
    assign d_valid[gi]  = ifc.out_valid;
    assign d_ovr[gi]    = ifc.overrange;
    assign d_orun[gi]   = ifc.overrun;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works in terms of "group sums", "the output is due 3 edges after the
  // hand-off" and "only one sample may be in flight".
  longint      cyc = 0;
  bit          model_ready = 0;
  bit          m_on   [3];
  longint      m_acc  [3];
  int          m_cnt  [3];
  int          m_g    [3];
  longint      m_dc   [3];
  bit          m_pend [3];
  longint      m_t0   [3];
  longint      m_avg  [3];
  longint      m_y    [3];
  bit          m_clip [3];
  bit          e_valid[3];
  bit          e_ovr  [3];
  bit          e_orun [3];
  logic [15:0] e_sample[3];
  longint      t_xs, t_avg, t_hp, t_hs;
  bit          t_ho, t_busy;

  always @(posedge clk) begin
    cyc++;
    if (reset) model_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_valid[i] = 1'b0;
      e_ovr[i]   = 1'b0;
      e_orun[i]  = 1'b0;
      if (reset) begin
        m_on[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_g[i] = 0;
        m_dc[i] = 0; m_pend[i] = 0; m_clip[i] = 0; e_sample[i] = 16'h0000;
      end else if (!enable) begin
        m_on[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_g[i] = 0; m_pend[i] = 0;
      end else if (!m_on[i]) begin
        m_on[i] = 1;
      end else begin
        t_xs   = (longint'(in_sample) - 2048) * 16;
        t_ho   = in_valid && (m_cnt[i] == (1 << pa(i)) - 1);
        t_busy = m_pend[i];
        t_avg  = 0;
        if (in_valid) begin
          if (t_ho) begin
            t_avg    = (m_acc[i] + t_xs) >>> pa(i);
            m_acc[i] = 0;
            m_cnt[i] = 0;
          end else begin
            m_acc[i] += t_xs;
            m_cnt[i]++;
          end
        end
        if (t_busy && cyc == m_t0[i] + 1) begin
          t_hp = m_avg[i] - (m_dc[i] >>> pd(i));
          m_dc[i] += t_hp;
          if (t_hp > 32767) begin
            t_hs = 32767; m_clip[i] = 1;
          end else if (t_hp < -32768) begin
            t_hs = -32768; m_clip[i] = 1;
          end else begin
            t_hs = t_hp; m_clip[i] = 0;
          end
          m_y[i] = (t_hs * longint'(m_g[i])) >>> pr(i);
        end
        if (t_busy && cyc == m_t0[i] + 3) begin
          e_valid[i]  = 1;
          e_sample[i] = 16'(m_y[i]);
          e_ovr[i]    = m_clip[i];
          if (m_g[i] < (1 << pr(i))) m_g[i]++;
          m_pend[i] = 0;
        end
        if (t_ho) begin
          if (t_busy) begin
            e_orun[i] = 1;
          end else begin
            m_pend[i] = 1;
            m_t0[i]   = cyc;
            m_avg[i]  = t_avg;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ready) begin
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("out_valid[%0d] cyc %0d", i, cyc), 16'(d_valid[i]), 16'(e_valid[i]));
        cmp($sformatf("out_sample[%0d] cyc %0d", i, cyc), d_sample[i], e_sample[i]);
        cmp($sformatf("overrange[%0d] cyc %0d", i, cyc), 16'(d_ovr[i]), 16'(e_ovr[i]));
        cmp($sformatf("overrun[%0d] cyc %0d", i, cyc), 16'(d_orun[i]), 16'(e_orun[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic [11:0] s);
    in_valid  = v;
    in_sample = s;
    @(negedge clk);
  endtask

  task automatic sample4(input logic [11:0] s);
    tick(1'b1, s);
    tick(1'b0, s);
    tick(1'b0, s);
    tick(1'b0, s);
  endtask

  task automatic group(input logic [11:0] s);
    repeat (4) sample4(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int nv, no;

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_sample = 12'h000;
    @(negedge clk);
    repeat (3) tick(1'b0, 12'h000);
    cmp("reset out_sample A", d_sample[0], 16'h0000);
    cmp("reset out_valid A", 16'(d_valid[0]), 16'h0000);
    cmp("reset overrun C", 16'(d_orun[2]), 16'h0000);

    // Mid-scale input: first output exactly 3 edges after the 4th strobe.
    reset = 1'b0; enable = 1'b1;
    tick(1'b0, 12'h800); tick(1'b0, 12'h800);
    repeat (3) sample4(12'h800);
    tick(1'b1, 12'h800); tick(1'b0, 12'h800); tick(1'b0, 12'h800);
    cmp("latency early valid A", 16'(d_valid[0]), 16'h0000);
    tick(1'b0, 12'h800);
    cmp("latency valid A", 16'(d_valid[0]), 16'h0001);
    cmp("latency sample A", d_sample[0], 16'h0000);
    cmp("latency overrun A", 16'(d_orun[0]), 16'h0000);

    // Constant 0xC00 from a clean reset: ramp up then DC decay.
    reset = 1'b1; tick(1'b0, 12'h800); reset = 1'b0;
    tick(1'b0, 12'h800); tick(1'b0, 12'h800);
    for (int k = 0; k < 300; k++) begin
      group(12'hC00);
      if (k == 0) cmp("ramp first output A", d_sample[0], 16'h0000);
      if (k == 1) begin
        cmp("ramp second valid A", 16'(d_valid[0]), 16'h0001);
        cmp("ramp second output A", d_sample[0], 16'h003F);
        cmp("ramp second output B", d_sample[1], 16'h1E00);
      end
    end

    // Negative average: (0x7FF0 - 0x8000) / 4 = -4.
    reset = 1'b1; tick(1'b0, 12'h800); reset = 1'b0;
    tick(1'b0, 12'h800); tick(1'b0, 12'h800);
    group(12'h800); group(12'h800);
    sample4(12'h800); sample4(12'h800); sample4(12'hFFF); sample4(12'h000);
    cmp("avg minus4 B", d_sample[1], 16'hFFFC);
    cmp("avg minus4 A floor", d_sample[0], 16'hFFFF);

    // Pull DC low, then full-scale positive must clip.
    repeat (64) group(12'h000);
    group(12'hFFF);
    cmp("clip sample B", d_sample[1], 16'h7FFF);
    cmp("clip overrange B", 16'(d_ovr[1]), 16'h0001);
    tick(1'b0, 12'hFFF);
    cmp("clip overrange pulse B", 16'(d_ovr[1]), 16'h0000);
    group(12'hFFF); group(12'hFFF);

    // Back-to-back strobes: AVG_LOG2=0 instance drops 3 of every 4 groups.
    nv = 0; no = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 20) tick(1'b1, 12'(k * 300 + 100));
      else        tick(1'b0, 12'h800);
      nv += int'(d_valid[2]);
      no += int'(d_orun[2]);
    end
    cmp("burst outputs C", 16'(nv), 16'd5);
    cmp("burst overruns C", 16'(no), 16'd15);

    // Enable drops while the pipeline is in SCALE.
    repeat (3) sample4(12'h900);
    tick(1'b1, 12'h900); tick(1'b0, 12'h900);
    enable = 1'b0;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      tick(k[0], 12'hA00);
      nv += int'(d_valid[0]) + int'(d_valid[1]) + int'(d_valid[2]);
    end
    cmp("disabled outputs", 16'(nv), 16'd0);
    enable = 1'b1;
    tick(1'b0, 12'h800); tick(1'b0, 12'h800);
    group(12'hFFF);
    cmp("reenable valid A", 16'(d_valid[0]), 16'h0001);
    cmp("reenable output A", d_sample[0], 16'h0000);
    group(12'hFFF);

    // Reset while in FILTER clears every output on that edge.
    repeat (3) sample4(12'hFFF);
    tick(1'b1, 12'hFFF);
    reset = 1'b1;
    tick(1'b0, 12'h800);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("filter reset sample[%0d]", i), d_sample[i], 16'h0000);
      cmp($sformatf("filter reset valid[%0d]", i), 16'(d_valid[i]), 16'h0000);
    end
    reset = 1'b0;
    repeat (6) tick(1'b0, 12'h800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
